universal_shift_register_burst: RTL

//  - Parametrised universal shift register: hold, shift right, shift left and parallel load.
//  - Adds a burst engine that performs N automatic shifts in one direction, with busy/done status.
//  - Generalises the fixed-width right-only preset register; drives LED/7-seg lab datapaths and serial links.

---
 rtl/shiftreg_pkg.sv | 18 +
 rtl/shiftreg_burst_ctrl.sv | 76 +++++++
 rtl/universal_shift_register_burst.sv | 109 ++++++++++
 3 files changed

// File: rtl/shiftreg_pkg.sv
// Shared encodings for the universal shift register with burst engine.
//   mode encodings : MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD
//   FSM encodings  : ST_IDLE, ST_BURST (one bit, legacy-compatible localparams)
//   burst direction: DIR_RIGHT, DIR_LEFT
package shiftreg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shiftreg_burst_ctrl.sv
// Burst controller: IDLE/BURST FSM with a down-counter of remaining shifts.
// Ports:
//   clk          in   rising-edge clock
//   clear        in   synchronous active-high reset
//   start        in   burst request, only looked at in IDLE
//   burst_dir    in   0 right, 1 left; captured with start
//   burst_count  in   number of shifts; captured with start
//   shift_en     out  datapath performs one burst shift at this edge
//   shift_dir    out  direction of that shift
//   busy         out  burst in progress
//   done         out  one-cycle completion pulse
//   state        out  current FSM state (debug visibility)
// Handshake: start is a single-cycle request accepted whenever state is IDLE;
// there is no back-pressure, a start seen during BURST is simply dropped.
module shiftreg_burst_ctrl
  import shiftreg_pkg::*;
#(
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   start,
  input  logic                   burst_dir,
  input  logic [COUNT_WIDTH-1:0] burst_count,
  output logic                   shift_en,
  output logic                   shift_dir,
  output logic                   busy,
  output logic                   done,
  output logic [0:0]             state
);

  logic [0:0]             state_q;
  logic [COUNT_WIDTH-1:0] remaining_q;
  logic                   dir_q;
  logic                   done_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      dir_q       <= DIR_RIGHT;
      done_q      <= 1'b0;
    end else begin
      // done is a pulse: cleared every edge unless re-asserted below.
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            dir_q       <= burst_dir;
            remaining_q <= burst_count;
            // A zero-length burst completes immediately without entering BURST.
            if (burst_count == '0) done_q  <= 1'b1;
            else                   state_q <= ST_BURST;
          end
        end
        ST_BURST: begin
          remaining_q <= remaining_q - 1'b1;
          // The edge that performs the last shift also leaves BURST, so busy
          // and done never overlap.
          if (remaining_q == COUNT_WIDTH'(1)) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign shift_en  = (state_q == ST_BURST);
  assign shift_dir = dir_q;
  assign busy      = (state_q == ST_BURST);
  assign done      = done_q;
  assign state     = state_q;

endmodule

// File: rtl/universal_shift_register_burst.sv
// Universal shift register (hold / shift right / shift left / parallel load)
// with a burst engine that performs N automatic shifts in one direction.
// Optional feature macro: SHIFTREG_ROTATE_EN adds the rotate input, which
// recirculates the shifted-out bit instead of using the serial input.
// Ports:
//   clockpulse        in   rising-edge clock
//   clear             in   synchronous active-high reset (highest priority)
//   enable            in   qualifies direct mode operations in IDLE
//   mode              in   00 hold, 01 shift right, 10 shift left, 11 load
//   serialInputRight  in   bit entering the MSB on a right shift
//   serialInputLeft   in   bit entering the LSB on a left shift
//   preset            in   parallel load value
//   start             in   burst request, sampled in IDLE
//   burstDir          in   burst direction, 0 right, 1 left
//   burstCount        in   number of burst shifts
//   rotate            in   (SHIFTREG_ROTATE_EN only) recirculate shifted-out bit
//   out / notout      out  register contents and its complement
//   serialOutRight    out  out[0]
//   serialOutLeft     out  out[WIDTH-1]
//   busy / done       out  burst status
module universal_shift_register_burst
  import shiftreg_pkg::*;
#(
  parameter int WIDTH       = 5,
  parameter int COUNT_WIDTH = 4
) (
  input  logic                   clockpulse,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic                   serialInputRight,
  input  logic                   serialInputLeft,
  input  logic [WIDTH-1:0]       preset,
  input  logic                   start,
  input  logic                   burstDir,
  input  logic [COUNT_WIDTH-1:0] burstCount,
`ifdef SHIFTREG_ROTATE_EN
  input  logic                   rotate,
`endif
  output logic [WIDTH-1:0]       out,
  output logic [WIDTH-1:0]       notout,
  output logic                   serialOutRight,
  output logic                   serialOutLeft,
  output logic                   busy,
  output logic                   done
);

  logic [WIDTH-1:0] out_q;
  logic             fill_right;
  logic             fill_left;
  logic [WIDTH-1:0] shr_value;
  logic [WIDTH-1:0] shl_value;
  logic             shift_en;
  logic             shift_dir;
  logic [0:0]       state;

  shiftreg_burst_ctrl #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_ctrl (
    .clk         (clockpulse),
    .clear       (clear),
    .start       (start),
    .burst_dir   (burstDir),
    .burst_count (burstCount),
    .shift_en    (shift_en),
    .shift_dir   (shift_dir),
    .busy        (busy),
    .done        (done),
    .state       (state)
  );

  // Bits entering the register; rotate is sampled live each cycle and
  // applies to both direct and burst shifts.
  always_comb begin
    fill_right = serialInputRight;
    fill_left  = serialInputLeft;
`ifdef SHIFTREG_ROTATE_EN
    if (rotate) begin
      fill_right = out_q[0];
      fill_left  = out_q[WIDTH-1];
    end
`endif
  end

  assign shr_value = {fill_right, out_q[WIDTH-1:1]};
  assign shl_value = {out_q[WIDTH-2:0], fill_left};

  always_ff @(posedge clockpulse) begin
    if (clear) begin
      out_q <= '0;
    end else if (shift_en) begin
      out_q <= (shift_dir == DIR_LEFT) ? shl_value : shr_value;
    end else if ((state == ST_IDLE) && !start && enable) begin
      // The start-capture edge leaves the register untouched, hence !start.
      case (mode)
        MODE_SHR:  out_q <= shr_value;
        MODE_SHL:  out_q <= shl_value;
        MODE_LOAD: out_q <= preset;
        default:   out_q <= out_q;
      endcase
    end
  end

  assign out            = out_q;
  assign notout         = ~out_q;
  assign serialOutRight = out_q[0];
  assign serialOutLeft  = out_q[WIDTH-1];

endmodule
